pipe_core_param: RTL and testbench
==================================

// Module: pipe_core_param
// PURPOSE
//  Parametrised successor of the 8-bit IF/ID/EX/WB pipelined core. Scales data, PC and register-index widths.
//  Adds a two-operand register ADD, full operand forwarding and an instruction-fetch valid handshake (stalls PC).
//  Adds a retired-instruction counter. Also exposes a writeback trace port for verification.
//  Instruction memory sits outside the core and is combinational. The core is the top-level datapath block.
// PARAMETERS
//  DATA_W     8   register / ALU data width
//  RA_W       3   register index width; 2**RA_W registers; INSTR_W = 2+2*RA_W
//  PC_W       8   program counter width, wraps modulo 2**PC_W
//  RESET_PC   0   PC value loaded on reset
//  CNT_W      32  retired-instruction counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  imem_addr    out  PC_W     fetch address, equals PC register (combinational)
//  imem_instr   in   INSTR_W  instruction at imem_addr; fields {op[1:0], rd[RA_W-1:0], src[RA_W-1:0]}
//  imem_valid   in   1        imem_instr is valid this cycle
//  wb_valid     out  1        a register write retires this cycle
//  wb_rd        out  RA_W     destination register of retiring write
//  wb_data      out  DATA_W   value being written
//  instret      out  CNT_W    count of retired instructions, including JMP
// BEHAVIOUR
//  Opcodes. zext/sext widen the field to DATA_W:
//   00 ADDI: R[rd] <= R[rd] + zext(src)
//   01 LI:   R[rd] <= sext(src)
//   10 ADD:  R[rd] <= R[rd] + R[src]
//   11 JMP:  PC <= PC_of_jmp + sext({rd,src}) to PC_W; no register write
//   All arithmetic is modulo 2**DATA_W; there are no flags.
//  Stages and valid bits:
//   IF: PC register. ID: IF/ID register, decode, regfile read, jump resolve.
//   EX: ALU. WB: regfile write. Each pipeline register carries a valid bit.
//   Bubbles never write, never count and never forward.
//  Fetch:
//   imem_valid=1 at an edge: IF/ID loads {instr, PC, valid=1} and PC <= PC+1, wrapping 2**PC_W-1 -> 0.
//   imem_valid=0 at an edge: PC holds and IF/ID loads a bubble.
//  Jump:
//   A valid JMP in ID loads the target into PC at the edge.
//   The same edge loads a bubble into IF/ID, discarding the fetched word whatever imem_valid is.
//   A JMP costs one cycle of penalty.
//  Latency:
//   An instruction accepted at edge E drives wb_* in the cycle after edge E+2.
//   Its register is written at edge E+3. wb_valid is high for exactly one cycle.
//  Hazards (no data stalls ever):
//   EX operands rd and src take wb_data when WB is valid, writes, and wb_rd matches (WB->EX forward).
//   The ID regfile read is write-through: a same-cycle WB write to that index is seen.
//   Consequently back-to-back dependent instructions produce correct results.
//  instret increments by 1 at each edge where a valid instruction leaves WB. It wraps at 2**CNT_W.
//  Reset, sync and active-high, with priority over all else, including mid-operation:
//   PC=RESET_PC; all valid bits 0; all registers 0.
//   wb_valid=0, wb_rd=0, wb_data=0; instret=0.
//   In-flight instructions are dropped with no write.
// TESTING (DATA_W=8, RA_W=3, PC_W=8)
//  1 Hold rst 2 cycles -> imem_addr=0x00, wb_valid=0, instret=0; the first accepted fetch appears on wb_* 3 cycles later.
//  2 Dependent pair: 0x4F (LI r1,-1), 0x0A (ADDI r1,2) -> wb_data 0xFF then 0x01 on consecutive cycles (WB->EX forward).
//  3 Two-ahead bypass: 0x4B (LI r1,3), 0x51 (LI r2,1), 0x91 (ADD r2,r1) -> third write wb_rd=2, wb_data=0x04.
//  4 JMP 0xFC at PC 0x04 -> imem_addr goes 0x05 then 0x00; the word at 0x05 never reaches WB; instret counts the JMP.
//  5 imem_valid low 3 cycles mid-stream -> imem_addr frozen, 3 bubble cycles on wb_valid, correct results after resume.
//  6 rst for 1 cycle with 3 instructions in flight -> no further wb_valid, PC=0, a later ADD r0,r0 writes 0x00.

Source files
------------

// File: rtl/pipe_core_param.sv
// Parametrised four-stage IF/ID/EX/WB core with register ADD, WB->EX forwarding,
// a write-through register file, a fetch valid handshake and a retired-instruction counter.
module pipe_core_param #(
  parameter int DATA_W   = 8,
  parameter int RA_W     = 3,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32,
  localparam int INSTR_W = 2 + 2 * RA_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               imem_valid,
  output logic               wb_valid,
  output logic [RA_W-1:0]    wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [1:0] OP_ADDI = 2'b00;
  localparam logic [1:0] OP_LI   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  logic [PC_W-1:0]    pc;
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;

  logic [DATA_W-1:0]  regs [2**RA_W];

  logic [1:0]                id_op;
  logic [RA_W-1:0]           id_rd;
  logic [RA_W-1:0]           id_src;
  logic signed [RA_W-1:0]    id_src_s;
  logic signed [2*RA_W-1:0]  id_off;
  logic [PC_W-1:0]           id_target;
  logic                      id_jump;
  logic [DATA_W-1:0]         id_imm;
  logic [DATA_W-1:0]         id_a;
  logic [DATA_W-1:0]         id_b;

  logic               idex_valid;
  logic [1:0]         idex_op;
  logic [RA_W-1:0]    idex_rd;
  logic [RA_W-1:0]    idex_src;
  logic [DATA_W-1:0]  idex_imm;
  logic [DATA_W-1:0]  idex_a;
  logic [DATA_W-1:0]  idex_b;

  logic [DATA_W-1:0]  ex_a;
  logic [DATA_W-1:0]  ex_b;
  logic [DATA_W-1:0]  ex_result;

  logic               exwb_valid;
  logic               exwb_we;

  assign imem_addr = pc;

  // Decode fields {op, rd, src}; the JMP offset is the whole {rd, src} field.
  assign id_op     = ifid_instr[INSTR_W-1 -: 2];
  assign id_rd     = ifid_instr[2*RA_W-1 -: RA_W];
  assign id_src    = ifid_instr[RA_W-1:0];
  assign id_src_s  = ifid_instr[RA_W-1:0];
  assign id_off    = ifid_instr[2*RA_W-1:0];
  assign id_target = ifid_pc + PC_W'(id_off);
  assign id_jump   = ifid_valid && (id_op == OP_JMP);
  assign id_imm    = (id_op == OP_LI) ? DATA_W'(id_src_s) : DATA_W'(id_src);

  // Write-through read: a write retiring this cycle is visible to ID.
  assign id_a = (wb_valid && wb_rd == id_rd)  ? wb_data : regs[id_rd];
  assign id_b = (wb_valid && wb_rd == id_src) ? wb_data : regs[id_src];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= PC_W'(RESET_PC);
      ifid_valid <= 1'b0;
    end else if (id_jump) begin
      // The word fetched behind a taken JMP is discarded regardless of imem_valid.
      pc         <= id_target;
      ifid_valid <= 1'b0;
    end else if (imem_valid) begin
      pc         <= pc + PC_W'(1);
      ifid_valid <= 1'b1;
    end else begin
      ifid_valid <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; the valid bit alone decides whether they act.
  always_ff @(posedge clk) begin
    if (imem_valid && !id_jump) begin
      ifid_instr <= imem_instr;
      ifid_pc    <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_valid <= 1'b0;
    else     idex_valid <= ifid_valid;
  end

  always_ff @(posedge clk) begin
    idex_op  <= id_op;
    idex_rd  <= id_rd;
    idex_src <= id_src;
    idex_imm <= id_imm;
    idex_a   <= id_a;
    idex_b   <= id_b;
  end

  always_comb begin
    ex_a      = (wb_valid && wb_rd == idex_rd)  ? wb_data : idex_a;
    ex_b      = (wb_valid && wb_rd == idex_src) ? wb_data : idex_b;
    ex_result = idex_imm;
    case (idex_op)
      OP_ADDI: ex_result = ex_a + idex_imm;
      OP_ADD:  ex_result = ex_a + ex_b;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exwb_valid <= 1'b0;
      exwb_we    <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      instret    <= '0;
    end else begin
      exwb_valid <= idex_valid;
      exwb_we    <= (idex_op != OP_JMP);
      wb_rd      <= idex_rd;
      wb_data    <= ex_result;
      if (exwb_valid) instret <= instret + CNT_W'(1);
    end
  end

  assign wb_valid = exwb_valid && exwb_we;

  // NOTE: the register file is architectural state and is cleared on reset, unlike pipeline payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_pipe_core_param.sv
// Self-checking bench for pipe_core_param: directed scenarios plus random programs
// compared against an instruction-level interpreter of the same memory image.
module tb_pipe_core_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_instr;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;
  logic [31:0] instret;

  logic [7:0] mem [256];
  assign imem_instr = mem[imem_addr];

  pipe_core_param #(
    .DATA_W(8), .RA_W(3), .PC_W(8), .RESET_PC(0), .CNT_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .imem_valid (imem_valid),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    int         k;
  } wb_ev_t;

  wb_ev_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     seen     = 0;
  bit     mon_en   = 1'b0;

  // Sequential interpreter: executes the program from PC 0 and lists every register
  // write in order, tagged with the number of instructions retired before it.
  task automatic build_model(input int n);
    logic [7:0] pc;
    logic [7:0] r;
    logic [7:0] ins;
    logic [7:0] rf [8];
    wb_ev_t     ev;
    exp_q.delete();
    pc = 8'h00;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    for (int k = 0; k < n; k++) begin
      ins = mem[pc];
      case (ins[7:6])
        2'b00:   r = rf[ins[5:3]] + {5'b0, ins[2:0]};
        2'b01:   r = {{5{ins[2]}}, ins[2:0]};
        2'b10:   r = rf[ins[5:3]] + rf[ins[2:0]];
        default: r = 8'h00;
      endcase
      if (ins[7:6] == 2'b11) begin
        pc = pc + {{2{ins[5]}}, ins[5:0]};
      end else begin
        rf[ins[5:3]] = r;
        ev.rd = ins[5:3];
        ev.data = r;
        ev.k = k;
        exp_q.push_back(ev);
        pc = pc + 8'h01;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    wb_ev_t ev;
    if (mon_en && wb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=%02h, required no write", wb_rd, wb_data);
      end else begin
        ev = exp_q.pop_front();
        seen++;
        if (wb_rd !== ev.rd || wb_data !== ev.data || instret !== 32'(ev.k)) begin
          failures++;
          $display("FAIL wb_stream: got rd=%0d data=%02h instret=%0d, required rd=%0d data=%02h instret=%0d",
                   wb_rd, wb_data, instret, ev.rd, ev.data, ev.k);
        end
      end
    end
  end

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic do_reset(input int n);
    mon_en     = 1'b0;
    rst        = 1'b1;
    imem_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fill_mem(8'h80);
    mem[0] = 8'h4F;
    do_reset(2);
    @(negedge clk);
    checks++;
    if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_pc: got %02h, required 00", imem_addr); end
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid: got %b, required 0", wb_valid); end
    checks++;
    if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret: got %0d, required 0", instret); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== (c == 2)) begin
        failures++;
        $display("FAIL latency_c%0d: got wb_valid=%b, required %b", c, wb_valid, (c == 2));
      end
    end
    checks++;
    if (wb_rd !== 3'd1 || wb_data !== 8'hFF || imem_addr !== 8'h03) begin
      failures++;
      $display("FAIL first_wb: got rd=%0d data=%02h pc=%02h, required rd=1 data=ff pc=03", wb_rd, wb_data, imem_addr);
    end
  endtask

  task automatic test_dependent();
    fill_mem(8'h80);
    mem[0] = 8'h4F;
    mem[1] = 8'h0A;
    do_reset(2);
    build_model(50);
    mon_en = 1'b1;
    for (int c = 0; c < 10 && !wb_valid; c++) @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 8'hFF) begin
      failures++;
      $display("FAIL dep_first: got valid=%b data=%02h, required valid=1 data=ff", wb_valid, wb_data);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 8'h01) begin
      failures++;
      $display("FAIL dep_forward: got valid=%b rd=%0d data=%02h, required valid=1 rd=1 data=01",
               wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_bypass();
    fill_mem(8'h80);
    mem[0] = 8'h4B;
    mem[1] = 8'h51;
    mem[2] = 8'h91;
    do_reset(2);
    build_model(50);
    mon_en = 1'b1;
    for (int c = 0; c < 10 && !wb_valid; c++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd2 || wb_data !== 8'h04) begin
      failures++;
      $display("FAIL bypass_add: got valid=%b rd=%0d data=%02h, required valid=1 rd=2 data=04",
               wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_jump();
    fill_mem(8'h80);
    mem[0] = 8'h43;
    mem[1] = 8'h52;
    mem[2] = 8'h6B;
    mem[3] = 8'h73;
    mem[4] = 8'hFC;
    mem[5] = 8'h7F;
    do_reset(2);
    build_model(100);
    mon_en = 1'b1;
    for (int c = 0; c < 10 && imem_addr !== 8'h04; c++) @(negedge clk);
    checks++;
    if (imem_addr !== 8'h04) begin failures++; $display("FAIL jmp_reach: got pc=%02h, required 04", imem_addr); end
    @(negedge clk);
    checks++;
    if (imem_addr !== 8'h05) begin failures++; $display("FAIL jmp_fetch_next: got pc=%02h, required 05", imem_addr); end
    @(negedge clk);
    checks++;
    if (imem_addr !== 8'h00) begin failures++; $display("FAIL jmp_target: got pc=%02h, required 00", imem_addr); end
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() > 100 - 6 * 4 + 10 && seen == 0) begin
      failures++;
      $display("FAIL jmp_progress: got no retirements, required some");
    end
  endtask

  task automatic test_fetch_stall();
    logic [7:0] a;
    int         bubbles;
    for (int i = 0; i < 256; i++) mem[i] = {2'($urandom_range(0, 2)), 6'($urandom)};
    do_reset(2);
    build_model(200);
    mon_en = 1'b1;
    repeat (6) tick();
    a = imem_addr;
    bubbles = 0;
    imem_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (imem_addr !== a) begin
          failures++;
          $display("FAIL stall_pc_c%0d: got %02h, required %02h", c, imem_addr, a);
        end
      end
      if (c == 2) imem_valid = 1'b1;
      if (!wb_valid) bubbles++;
    end
    checks++;
    if (bubbles !== 3) begin failures++; $display("FAIL stall_bubbles: got %0d, required 3", bubbles); end
  endtask

  task automatic test_reset_midstream();
    fill_mem(8'h80);
    mem[1] = 8'h43;
    do_reset(2);
    build_model(100);
    mon_en = 1'b1;
    repeat (5) tick();
    do_reset(1);
    build_model(100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0) begin failures++; $display("FAIL midrst_drop_c%0d: got wb_valid=1, required 0", c); end
      if (c == 0) begin
        checks++;
        if (imem_addr !== 8'h00 || instret !== 32'd0) begin
          failures++;
          $display("FAIL midrst_state: got pc=%02h instret=%0d, required pc=00 instret=0", imem_addr, instret);
        end
      end
    end
    mon_en = 1'b1;
    for (int c = 0; c < 10 && !wb_valid; c++) @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd0 || wb_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_add: got valid=%b rd=%0d data=%02h, required valid=1 rd=0 data=00",
               wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] ins;
    for (int i = 0; i < 256; i++) begin
      ins = 8'($urandom);
      if (ins == 8'hC0) ins = 8'hC1;
      mem[i] = ins;
    end
    do_reset(2);
    build_model(2000);
    mon_en = 1'b1;
    repeat (400) begin
      @(posedge clk);
      #1 imem_valid = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    checks++;
    if (instret < 32'd100) begin failures++; $display("FAIL rand_progress: got instret=%0d, required >=100", instret); end
    mon_en = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b0;
    fill_mem(8'h80);
    test_reset();
    test_dependent();
    test_bypass();
    test_jump();
    test_fetch_stall();
    test_reset_midstream();
    test_random();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
